// File: rtl/bpu_btb_pkg.sv
// bpu_btb_pkg: shared sizes, counter codes and state types for the branch target buffer
package bpu_btb_pkg;
  localparam int GRLEN = 32;
  localparam int ENTRIES = 64;
  localparam int IDX_W = 6;
  localparam int TAG_W = GRLEN - 2 - IDX_W;
  localparam logic [1:0] BTB_CTR_SNT = 2'b00;
  localparam logic [1:0] BTB_CTR_WNT = 2'b01;
  localparam logic [1:0] BTB_CTR_WT = 2'b10;
  localparam logic [1:0] BTB_CTR_ST = 2'b11;
  localparam logic [1:0] BTB_CTR_ALLOC_COND = 2'b10;
  typedef enum logic [1:0] {CTR_HOLD, CTR_INC, CTR_DEC, CTR_STRONG} ctr_op_e;
  typedef enum logic {INV_IDLE, INV_SWEEP} inv_state_e;
endpackage

// File: rtl/bpu_btb_if.sv
// bpu_btb_if: fetch lookup, BRU update, flush and invalidate signals of the branch target buffer
interface bpu_btb_if;
  import bpu_btb_pkg::*;
  logic lkup_valid;
  logic [GRLEN-1:0] lkup_pc;
  logic pred_valid;
  logic pred_taken;
  logic [GRLEN-1:0] pred_target;
  logic upd_valid;
  logic [GRLEN-1:0] upd_pc;
  logic upd_taken;
  logic [GRLEN-1:0] upd_target;
  logic upd_uncond;
  logic flush;
  logic inv_req;
  logic inv_busy;
  modport master (
    output lkup_valid, lkup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_uncond, flush, inv_req,
    input pred_valid, pred_taken, pred_target, inv_busy
  );
  modport slave (
    input lkup_valid, lkup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_uncond, flush, inv_req,
    output pred_valid, pred_taken, pred_target, inv_busy
  );
endinterface

// File: rtl/bpu_sat_ctr.sv
// bpu_sat_ctr: next state of a 2-bit saturating direction counter
module bpu_sat_ctr
  import bpu_btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  ctr_op_e    op,
  output logic [1:0] nxt
);
  always_comb begin
    nxt = op == CTR_STRONG ? BTB_CTR_ST :
          op == CTR_INC ? (ctr == BTB_CTR_ST ? ctr : ctr + 2'd1) :
          op == CTR_DEC ? (ctr == BTB_CTR_SNT ? ctr : ctr - 2'd1) : ctr;
  end
endmodule

// File: rtl/bpu_btb.sv
// bpu_btb: direct-mapped branch target buffer with 2-bit direction counters and invalidate sweep
module bpu_btb
  import bpu_btb_pkg::*;
(
  input logic clk,
  input logic reset,
  bpu_btb_if.slave bus
);
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [GRLEN-3:0] tgt_q [ENTRIES];
  logic [1:0] ctr_q [ENTRIES];
  inv_state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic sweep, l_taken, u_hit, u_write;
  logic [1:0] u_ctr;
  ctr_op_e u_op;
  logic unused;
  assign unused = ^{bus.lkup_pc[1:0], bus.upd_pc[1:0], bus.upd_target[1:0]};
  assign l_idx = bus.lkup_pc[IDX_W+1:2];
  assign l_tag = bus.lkup_pc[GRLEN-1:IDX_W+2];
  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[GRLEN-1:IDX_W+2];
  assign sweep = state_q == INV_SWEEP;
  assign bus.inv_busy = sweep;
  assign l_taken = !sweep && valid_q[l_idx] && tag_q[l_idx] == l_tag && ctr_q[l_idx][1];
  assign u_hit = valid_q[u_idx] && tag_q[u_idx] == u_tag;
  assign u_write = bus.upd_valid && !sweep && (u_hit || bus.upd_taken);
  assign u_op = bus.upd_uncond ? CTR_STRONG : bus.upd_taken ? CTR_INC : CTR_DEC;
  bpu_sat_ctr u_sat (.ctr(ctr_q[u_idx]), .op(u_op), .nxt(u_ctr));
  always_comb begin
    state_d = state_q;
    state_d = sweep ? (cnt_q == IDX_W'(ENTRIES - 1) ? INV_IDLE : INV_SWEEP) :
              (bus.inv_req ? INV_SWEEP : INV_IDLE);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INV_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= sweep ? cnt_q + IDX_W'(1) : '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.pred_valid <= 1'b0;
      bus.pred_taken <= 1'b0;
      bus.pred_target <= '0;
    end else begin
      bus.pred_valid <= bus.lkup_valid && !bus.flush;
      bus.pred_taken <= l_taken;
      bus.pred_target <= l_taken ? {tgt_q[l_idx], 2'b00} :
                         {bus.lkup_pc[GRLEN-1:2] + (GRLEN-2)'(1), 2'b00};
    end
  end
  // a not-taken hit on a conditional branch only weakens the counter; the target is kept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= BTB_CTR_WNT;
      end
    end else if (sweep) begin
      valid_q[cnt_q] <= 1'b0;
    end else if (u_write) begin
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx] <= u_tag;
      ctr_q[u_idx] <= u_hit ? u_ctr : (bus.upd_uncond ? BTB_CTR_ST : BTB_CTR_ALLOC_COND);
      if (!u_hit || bus.upd_uncond || bus.upd_taken) tgt_q[u_idx] <= bus.upd_target[GRLEN-1:2];
    end
  end
endmodule
